// File: rtl/motion_sequencer.sv
// motion_sequencer
//   Converts per-cycle motion commands from the wall-following decision FSM
//   into timed motor/arm actuation segments. Every segment is followed by a
//   motors-off settle period, so the drive never switches enable or direction
//   without a dead time in between. The block also keeps simple odometry.
//
// Ports
//   c1          in   system clock, rising edge
//   reset       in   synchronous, active-high reset
//   avancar     in   forward command (sampled only while idle)
//   girar       in   rotate-left command (sampled only while idle)
//   remover     in   debris-removal command (sampled only while idle)
//   motor_l_en  out  left motor enable
//   motor_l_dir out  left motor direction (1 = forward)
//   motor_r_en  out  right motor enable
//   motor_r_dir out  right motor direction (1 = forward)
//   arm_en      out  removal arm enable
//   busy        out  high whenever the sequencer is not idle
//   done        out  one-cycle pulse on return to idle
//   move_count  out  completed forward segments, wraps modulo 256
//   heading     out  completed left turns, wraps modulo 4
//
// Command handshake: there is no ready signal. A command is accepted only on
// an edge where the internal state is IDLE; the decision FSM uses busy/done
// to know when the next command will be taken. Commands seen while busy are
// dropped, not queued. The internal 'state' register is the FSM state.

module motion_sequencer #(
    parameter int MOVE_CYCLES = 16,
    parameter int TURN_CYCLES = 8,
    parameter int ARM_CYCLES  = 12,
    parameter int DEAD_CYCLES = 2,
    parameter int TIMER_W     = 16
) (
    input  logic       c1,
    input  logic       reset,
    input  logic       avancar,
    input  logic       girar,
    input  logic       remover,
    output logic       motor_l_en,
    output logic       motor_l_dir,
    output logic       motor_r_en,
    output logic       motor_r_dir,
    output logic       arm_en,
    output logic       busy,
    output logic       done,
    output logic [7:0] move_count,
    output logic [1:0] heading
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FWD    = 3'd1,
        TURN   = 3'd2,
        ARM    = 3'd3,
        SETTLE = 3'd4
    } state_t;

    // Timer reload values: the timer counts down to 0, so a segment of N
    // cycles loads N-1 on the entry edge.
    localparam logic [TIMER_W-1:0] MOVE_LD = TIMER_W'(MOVE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TURN_LD = TIMER_W'(TURN_CYCLES - 1);
    localparam logic [TIMER_W-1:0] ARM_LD  = TIMER_W'(ARM_CYCLES - 1);
    localparam logic [TIMER_W-1:0] DEAD_LD = TIMER_W'(DEAD_CYCLES - 1);

    // Motor drive word {l_en, l_dir, r_en, r_dir}
    localparam logic [3:0] MOT_FWD  = 4'b1111;
    localparam logic [3:0] MOT_TURN = 4'b1011;
    localparam logic [3:0] MOT_OFF  = 4'b0000;

    state_t             state;
    logic [TIMER_W-1:0] timer;
    logic               pending_turn;
    logic [3:0]         motor;

    assign motor_l_en  = motor[3];
    assign motor_l_dir = motor[2];
    assign motor_r_en  = motor[1];
    assign motor_r_dir = motor[0];

    always_ff @(posedge c1) begin
        if (reset) begin
            state        <= IDLE;
            timer        <= '0;
            pending_turn <= 1'b0;
            motor        <= MOT_OFF;
            arm_en       <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            move_count   <= 8'd0;
            heading      <= 2'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (remover) begin
                        state  <= ARM;
                        timer  <= ARM_LD;
                        arm_en <= 1'b1;
                        busy   <= 1'b1;
                    end else if (avancar) begin
                        // avancar+girar together is a forward-then-turn move
                        state        <= FWD;
                        timer        <= MOVE_LD;
                        pending_turn <= girar;
                        motor        <= MOT_FWD;
                        busy         <= 1'b1;
                    end else if (girar) begin
                        state <= TURN;
                        timer <= TURN_LD;
                        motor <= MOT_TURN;
                        busy  <= 1'b1;
                    end
                end
                FWD: begin
                    if (timer == '0) begin
                        state      <= SETTLE;
                        timer      <= DEAD_LD;
                        motor      <= MOT_OFF;
                        move_count <= move_count + 8'd1;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                TURN: begin
                    if (timer == '0) begin
                        state   <= SETTLE;
                        timer   <= DEAD_LD;
                        motor   <= MOT_OFF;
                        heading <= heading + 2'd1;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                ARM: begin
                    if (timer == '0) begin
                        state  <= SETTLE;
                        timer  <= DEAD_LD;
                        arm_en <= 1'b0;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                SETTLE: begin
                    if (timer == '0) begin
                        if (pending_turn) begin
                            state        <= TURN;
                            timer        <= TURN_LD;
                            pending_turn <= 1'b0;
                            motor        <= MOT_TURN;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    timer  <= '0;
                    motor  <= MOT_OFF;
                    arm_en <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_motion_sequencer.sv
// tb_motion_sequencer
//   Table-driven bench for motion_sequencer at default parameters. Each table
//   row is a command plus the odometry expected after it completes; the
//   per-cycle output trace of the command is built from segment lengths and
//   pushed to a queue, then popped and compared every cycle. Hand-written
//   sequences cover counter wrap and mid-segment reset.

module tb_motion_sequencer;

    localparam int MOVE = 16;
    localparam int TURN = 8;
    localparam int ARMC = 12;
    localparam int DEAD = 2;

    // Packed control outputs {l_en, l_dir, r_en, r_dir, arm_en, busy, done}
    localparam int W = 7;
    localparam logic [W-1:0] P_FWD    = 7'b1111010;
    localparam logic [W-1:0] P_TURN   = 7'b1011010;
    localparam logic [W-1:0] P_ARM    = 7'b0000110;
    localparam logic [W-1:0] P_SETTLE = 7'b0000010;
    localparam logic [W-1:0] P_DONE   = 7'b0000001;
    localparam logic [W-1:0] P_IDLE   = 7'b0000000;

    logic       c1;
    logic       reset;
    logic       avancar;
    logic       girar;
    logic       remover;
    logic       motor_l_en;
    logic       motor_l_dir;
    logic       motor_r_en;
    logic       motor_r_dir;
    logic       arm_en;
    logic       busy;
    logic       done;
    logic [7:0] move_count;
    logic [1:0] heading;

    int tests_run;
    int tests_failed;

    logic [W-1:0] exp_q[$];

    typedef struct {
        string      name;
        logic       a;
        logic       g;
        logic       r;
        logic       noise;
        logic [7:0] exp_mc;
        logic [1:0] exp_hd;
    } vec_t;

    vec_t vecs[12];

    motion_sequencer dut (
        .c1          (c1),
        .reset       (reset),
        .avancar     (avancar),
        .girar       (girar),
        .remover     (remover),
        .motor_l_en  (motor_l_en),
        .motor_l_dir (motor_l_dir),
        .motor_r_en  (motor_r_en),
        .motor_r_dir (motor_r_dir),
        .arm_en      (arm_en),
        .busy        (busy),
        .done        (done),
        .move_count  (move_count),
        .heading     (heading)
    );

    // Clock / reset
    initial c1 = 1'b0;
    always #5 c1 = ~c1;

    function automatic logic [W-1:0] outs();
        return {motor_l_en, motor_l_dir, motor_r_en, motor_r_dir, arm_en, busy, done};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_seg(input int n, input logic [W-1:0] v);
        for (int i = 0; i < n; i++) exp_q.push_back(v);
    endtask

    // Build the expected per-cycle trace of one command from segment lengths.
    task automatic push_cmd(input logic a, input logic g, input logic r);
        if (r) begin
            push_seg(ARMC, P_ARM);
            push_seg(DEAD, P_SETTLE);
            push_seg(1, P_DONE);
        end else if (a) begin
            push_seg(MOVE, P_FWD);
            push_seg(DEAD, P_SETTLE);
            if (g) begin
                push_seg(TURN, P_TURN);
                push_seg(DEAD, P_SETTLE);
            end
            push_seg(1, P_DONE);
        end else if (g) begin
            push_seg(TURN, P_TURN);
            push_seg(DEAD, P_SETTLE);
            push_seg(1, P_DONE);
        end else begin
            push_seg(1, P_IDLE);
        end
    endtask

    // Called right after a negedge. Drives the command for one edge, then
    // pops/compares every cycle; with noise, random commands are driven while
    // busy. Inputs return to 0 on the final (done) cycle so the next call can
    // issue its command back-to-back on that same cycle.
    task automatic run_cmd(input string name, input logic a, input logic g, input logic r,
                           input logic noise, input logic [7:0] exp_mc, input logic [1:0] exp_hd);
        logic [W-1:0] e;
        avancar = a;
        girar   = g;
        remover = r;
        push_cmd(a, g, r);
        while (exp_q.size() > 0) begin
            @(negedge c1);
            e = exp_q.pop_front();
            check({name, " outs"}, 32'(outs()), 32'(e));
            if (noise && exp_q.size() > 0) begin
                avancar = 1'($urandom_range(0, 1));
                girar   = 1'($urandom_range(0, 1));
                remover = 1'($urandom_range(0, 1));
            end else begin
                avancar = 1'b0;
                girar   = 1'b0;
                remover = 1'b0;
            end
        end
        check({name, " move_count"}, 32'(move_count), 32'(exp_mc));
        check({name, " heading"}, 32'(heading), 32'(exp_hd));
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        avancar      = 1'b0;
        girar        = 1'b0;
        remover      = 1'b0;
        reset        = 1'b1;

        vecs[0]  = '{"fwd",          1, 0, 0, 0, 8'd1, 2'd1 - 2'd1};
        vecs[1]  = '{"turn1",        0, 1, 0, 0, 8'd1, 2'd1};
        vecs[2]  = '{"turn2",        0, 1, 0, 0, 8'd1, 2'd2};
        vecs[3]  = '{"turn3",        0, 1, 0, 0, 8'd1, 2'd3};
        vecs[4]  = '{"turn4_wrap",   0, 1, 0, 0, 8'd1, 2'd0};
        vecs[5]  = '{"compound",     1, 1, 0, 0, 8'd2, 2'd1};
        vecs[6]  = '{"all_arm_wins", 1, 1, 1, 0, 8'd2, 2'd1};
        vecs[7]  = '{"arm",          0, 0, 1, 0, 8'd2, 2'd1};
        vecs[8]  = '{"fwd_noise",    1, 0, 0, 1, 8'd3, 2'd1};
        vecs[9]  = '{"turn_noise",   0, 1, 0, 1, 8'd3, 2'd2};
        vecs[10] = '{"cmp_noise",    1, 1, 0, 1, 8'd4, 2'd3};
        vecs[11] = '{"no_cmd",       0, 0, 0, 0, 8'd4, 2'd3};

        repeat (3) @(posedge c1);
        @(negedge c1);
        check("reset outs", 32'(outs()), 32'(P_IDLE));
        check("reset move_count", 32'(move_count), 32'd0);
        check("reset heading", 32'(heading), 32'd0);
        reset = 1'b0;
        @(negedge c1);
        check("idle outs", 32'(outs()), 32'(P_IDLE));

        for (int i = 0; i < 12; i++) begin
            run_cmd(vecs[i].name, vecs[i].a, vecs[i].g, vecs[i].r,
                    vecs[i].noise, vecs[i].exp_mc, vecs[i].exp_hd);
        end

        // Forward moves back-to-back with noise until move_count wraps to 0.
        for (int i = 0; i < 252; i++) begin
            run_cmd("wrap_fwd", 1'b1, 1'b0, 1'b0, 1'b1, 8'((5 + i) % 256), 2'd3);
        end
        check("wrap move_count zero", 32'(move_count), 32'd0);

        // Reset asserted during cycle 5 of a forward segment.
        avancar = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge c1);
            check("rst_mid fwd outs", 32'(outs()), 32'(P_FWD));
            avancar = 1'b0;
        end
        reset = 1'b1;
        @(negedge c1);
        check("rst_mid outs", 32'(outs()), 32'(P_IDLE));
        check("rst_mid move_count", 32'(move_count), 32'd0);
        check("rst_mid heading", 32'(heading), 32'd0);
        reset = 1'b0;
        @(negedge c1);
        check("rst_mid no done", 32'(outs()), 32'(P_IDLE));
        run_cmd("post_rst_fwd", 1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 2'd0);
        run_cmd("post_rst_cmp", 1'b1, 1'b1, 1'b0, 1'b0, 8'd2, 2'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        tests_failed++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
